// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control FSM: sequences the shared memory, ALU and register file,
// stalls on the memory ready handshake and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegW,
  output logic             LinkW,
  output logic             MemW,
  output logic             MemReq,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  // Raw enables before reset gating
  logic ir_write_s;
  logic next_pc_s;
  logic reg_w_s;
  logic link_w_s;
  logic mem_w_s;
  logic mem_req_s;

  logic rd_is_pc_s;
  logic is_cmp_s;
  logic unused_funct_s;

  assign rd_is_pc_s     = (Rd == 4'd15);
  assign is_cmp_s       = (Funct[4:3] == 2'b10);
  assign unused_funct_s = ^Funct[2:1];

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = S_FETCH;
    ir_write_s = 1'b0;
    next_pc_s  = 1'b0;
    reg_w_s    = 1'b0;
    link_w_s   = 1'b0;
    mem_w_s    = 1'b0;
    mem_req_s  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = MemReady;
        next_pc_s  = MemReady;
        state_d    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          default: state_d = S_BRANCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        state_d   = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_s   = CondEx;
        next_pc_s = CondEx & rd_is_pc_s;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        // A failed condition drops the access at once instead of waiting on memory
        AdrSrc    = 1'b1;
        mem_req_s = CondEx;
        mem_w_s   = CondEx;
        state_d   = (CondEx && !MemReady) ? S_MEMWR : S_FETCH;
      end
      S_EXECR: begin
        ALUSrcB = 2'b00;
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        if (is_cmp_s) begin
          reg_w_s   = 1'b0;
          next_pc_s = 1'b0;
        end else begin
          reg_w_s   = CondEx;
          next_pc_s = CondEx & rd_is_pc_s;
        end
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        next_pc_s = CondEx;
        // BL: link gets the PC register while the target flows via ALUResult
        if ((Op == 2'b11) && CondEx) begin
          reg_w_s   = 1'b1;
          link_w_s  = 1'b1;
          ResultSrc = 2'b11;
        end else begin
          reg_w_s   = 1'b0;
          link_w_s  = 1'b0;
          ResultSrc = 2'b10;
        end
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retirement is counted on every entry into FETCH from another state
  always_comb begin
    instret_d = instret_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  assign IRWrite = reset & ir_write_s;
  assign NextPC  = reset & next_pc_s;
  assign RegW    = reset & reg_w_s;
  assign LinkW   = reset & link_w_s;
  assign MemW    = reset & mem_w_s;
  assign MemReq  = reset & mem_req_s;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes the expected
// output vector and retired count, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic        CondEx;
  logic        MemReady;
  logic        IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, LinkW, MemW, MemReq;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [3:0]  state;
  logic [31:0] instret;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [16:0] vec;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .NextPC(NextPC), .RegW(RegW), .LinkW(LinkW), .MemW(MemW), .MemReq(MemReq),
    .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {state, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, LinkW, MemW, MemReq}
  function automatic logic [16:0] ev(input logic [3:0] st, input logic irw, input logic adr,
                                     input logic asa, input logic [1:0] asb, input logic [1:0] rs,
                                     input logic aop, input logic npc, input logic rw,
                                     input logic lw, input logic mw, input logic mr);
    return {st, irw, adr, asa, asb, rs, aop, npc, rw, lw, mw, mr};
  endfunction

  function automatic logic [16:0] e_fetch(input logic r);
    return ev(4'd0, r, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [16:0] e_decode();
    return ev(4'd1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memadr();
    return ev(4'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memrd();
    return ev(4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [16:0] e_memwb(input logic npc, input logic rw);
    return ev(4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, npc, rw, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memwr(input logic c);
    return ev(4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c, c);
  endfunction
  function automatic logic [16:0] e_execr();
    return ev(4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_execi();
    return ev(4'd7, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_aluwb(input logic npc, input logic rw);
    return ev(4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, npc, rw, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_branch(input logic c, input logic l);
    return ev(4'd9, 1'b0, 1'b0, 1'b1, 2'b01, l ? 2'b11 : 2'b10, 1'b0, c, l, l, 1'b0, 1'b0);
  endfunction

  // Drive one cycle of inputs, record the expectation, advance to just after the next edge
  task automatic cyc(input string tag, input logic rst, input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] rd, input logic cx, input logic mr,
                     input logic [16:0] vec, input logic [31:0] cnt);
    exp_t e;
    reset    = rst;
    Op       = op;
    Funct    = fn;
    Rd       = rd;
    CondEx   = cx;
    MemReady = mr;
    e.tag = tag;
    e.vec = vec;
    e.cnt = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_val({e.tag, ".out"},
                {15'd0, state, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                 NextPC, RegW, LinkW, MemW, MemReq},
                {15'd0, e.vec});
      check_val({e.tag, ".instret"}, instret, e.cnt);
    end
  end

  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0; MemReady = 1'b0;
    @(posedge clk);
    #1;
    // Reset holds FETCH with all enables forced low even though MemReady is high
    cyc("rst0", 1'b0, OP_DP, 6'd0, 4'd0, 1'b1, 1'b1,
        ev(4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd0);

    // ADD R1,R2,R3
    cyc("add.fetch",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_fetch(1'b1), 32'd0);
    cyc("add.decode", 1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_decode(), 32'd0);
    cyc("add.execr",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_execr(), 32'd0);
    cyc("add.aluwb",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_aluwb(1'b0, 1'b1), 32'd0);

    // LDR with memory stalls in FETCH and MEMRD
    for (int i = 0; i < 2; i++)
      cyc("ldr.fetchw", 1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b0, e_fetch(1'b0), 32'd1);
    cyc("ldr.fetch",  1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b1, e_fetch(1'b1), 32'd1);
    cyc("ldr.decode", 1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b1, e_decode(), 32'd1);
    cyc("ldr.memadr", 1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b1, e_memadr(), 32'd1);
    for (int i = 0; i < 3; i++)
      cyc("ldr.memrdw", 1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b0, e_memrd(), 32'd1);
    cyc("ldr.memrd",  1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b1, e_memrd(), 32'd1);
    cyc("ldr.memwb",  1'b1, OP_MEM, 6'b011001, 4'd2, 1'b1, 1'b0, e_memwb(1'b0, 1'b1), 32'd1);

    // STR with failed condition: one MEMWR cycle, no write, still retires
    cyc("strn.fetch",  1'b1, OP_MEM, 6'b011000, 4'd3, 1'b0, 1'b1, e_fetch(1'b1), 32'd2);
    cyc("strn.decode", 1'b1, OP_MEM, 6'b011000, 4'd3, 1'b0, 1'b0, e_decode(), 32'd2);
    cyc("strn.memadr", 1'b1, OP_MEM, 6'b011000, 4'd3, 1'b0, 1'b0, e_memadr(), 32'd2);
    cyc("strn.memwr",  1'b1, OP_MEM, 6'b011000, 4'd3, 1'b0, 1'b0, e_memwr(1'b0), 32'd2);

    // BL taken, then BL not taken
    cyc("bl.fetch",   1'b1, 2'b11, 6'b000000, 4'd0, 1'b1, 1'b1, e_fetch(1'b1), 32'd3);
    cyc("bl.decode",  1'b1, 2'b11, 6'b000000, 4'd0, 1'b1, 1'b0, e_decode(), 32'd3);
    cyc("bl.branch",  1'b1, 2'b11, 6'b000000, 4'd0, 1'b1, 1'b0, e_branch(1'b1, 1'b1), 32'd3);
    cyc("bln.fetch",  1'b1, 2'b11, 6'b000000, 4'd0, 1'b0, 1'b1, e_fetch(1'b1), 32'd4);
    cyc("bln.decode", 1'b1, 2'b11, 6'b000000, 4'd0, 1'b0, 1'b1, e_decode(), 32'd4);
    cyc("bln.branch", 1'b1, 2'b11, 6'b000000, 4'd0, 1'b0, 1'b1, e_branch(1'b0, 1'b0), 32'd4);

    // Plain branch B (Op=10) taken: NextPC only, no link
    cyc("b.fetch",  1'b1, 2'b10, 6'b000000, 4'd0, 1'b1, 1'b1, e_fetch(1'b1), 32'd5);
    cyc("b.decode", 1'b1, 2'b10, 6'b000000, 4'd0, 1'b1, 1'b0, e_decode(), 32'd5);
    cyc("b.branch", 1'b1, 2'b10, 6'b000000, 4'd0, 1'b1, 1'b0, e_branch(1'b1, 1'b0), 32'd5);

    // CMP with Rd=15 never writes the PC
    cyc("cmp.fetch",  1'b1, OP_DP, 6'b010101, 4'd15, 1'b1, 1'b1, e_fetch(1'b1), 32'd6);
    cyc("cmp.decode", 1'b1, OP_DP, 6'b010101, 4'd15, 1'b1, 1'b1, e_decode(), 32'd6);
    cyc("cmp.execr",  1'b1, OP_DP, 6'b010101, 4'd15, 1'b1, 1'b1, e_execr(), 32'd6);
    cyc("cmp.aluwb",  1'b1, OP_DP, 6'b010101, 4'd15, 1'b1, 1'b1, e_aluwb(1'b0, 1'b0), 32'd6);

    // ADD immediate to R15 writes the PC
    cyc("addpc.fetch",  1'b1, OP_DP, 6'b101000, 4'd15, 1'b1, 1'b1, e_fetch(1'b1), 32'd7);
    cyc("addpc.decode", 1'b1, OP_DP, 6'b101000, 4'd15, 1'b1, 1'b1, e_decode(), 32'd7);
    cyc("addpc.execi",  1'b1, OP_DP, 6'b101000, 4'd15, 1'b1, 1'b1, e_execi(), 32'd7);
    cyc("addpc.aluwb",  1'b1, OP_DP, 6'b101000, 4'd15, 1'b1, 1'b1, e_aluwb(1'b1, 1'b1), 32'd7);

    // LDR to R15 with CondEx set loads the PC
    cyc("ldpc.fetch",  1'b1, OP_MEM, 6'b011001, 4'd15, 1'b1, 1'b1, e_fetch(1'b1), 32'd8);
    cyc("ldpc.decode", 1'b1, OP_MEM, 6'b011001, 4'd15, 1'b1, 1'b1, e_decode(), 32'd8);
    cyc("ldpc.memadr", 1'b1, OP_MEM, 6'b011001, 4'd15, 1'b1, 1'b1, e_memadr(), 32'd8);
    cyc("ldpc.memrd",  1'b1, OP_MEM, 6'b011001, 4'd15, 1'b1, 1'b1, e_memrd(), 32'd8);
    cyc("ldpc.memwb",  1'b1, OP_MEM, 6'b011001, 4'd15, 1'b1, 1'b1, e_memwb(1'b1, 1'b1), 32'd8);

    // STR with CondEx: MemW held across a stall
    cyc("str.fetch",  1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_fetch(1'b1), 32'd9);
    cyc("str.decode", 1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_decode(), 32'd9);
    cyc("str.memadr", 1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_memadr(), 32'd9);
    cyc("str.memwrw", 1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b0, e_memwr(1'b1), 32'd9);
    cyc("str.memwr",  1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_memwr(1'b1), 32'd9);

    // Reset asserted mid-STR while memory is stalled
    cyc("rst.fetch",  1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_fetch(1'b1), 32'd10);
    cyc("rst.decode", 1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b1, e_decode(), 32'd10);
    cyc("rst.memadr", 1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b0, e_memadr(), 32'd10);
    cyc("rst.memwr",  1'b1, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b0, e_memwr(1'b1), 32'd10);
    cyc("rst.inrst",  1'b0, OP_MEM, 6'b011000, 4'd4, 1'b1, 1'b0,
        ev(4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd10);
    cyc("post.fetch",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_fetch(1'b1), 32'd0);
    cyc("post.decode", 1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_decode(), 32'd0);
    cyc("post.execr",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_execr(), 32'd0);
    cyc("post.aluwb",  1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b1, e_aluwb(1'b0, 1'b1), 32'd0);
    cyc("post.done",   1'b1, OP_DP, 6'b001000, 4'd1, 1'b1, 1'b0, e_fetch(1'b0), 32'd1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
